// File: rtl/dds_ctrl_pkg.sv
// Shared definitions for the DDS sweep controller.
//   - Sweep mode encodings (value of the mode input).
//   - Controller FSM state encodings.
//   - Default widths: frequency word N and dwell counter DW.
package dds_ctrl_pkg;

  localparam int unsigned N_DEF  = 24;
  localparam int unsigned DW_DEF = 16;

  typedef enum logic [1:0] {
    MODE_UP  = 2'b00,
    MODE_DN  = 2'b01,
    MODE_TRI = 2'b10,
    MODE_SAW = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_FINISH = 2'b10
  } state_e;

endpackage

// File: rtl/dds_step_alu.sv
// Clamped frequency-word step, purely combinational.
//   i_cur, i_step, i_lo, i_hi : current word, increment, sweep bounds
//   i_dir                      : 1 = step up towards i_hi, 0 = step down towards i_lo
//   o_next                     : next word, clamped into [i_lo, i_hi]
//   o_at_limit                 : i_cur already sits on the bound in direction i_dir
module dds_step_alu #(
  parameter int unsigned N = 24
) (
  input  logic [N-1:0] i_cur,
  input  logic [N-1:0] i_step,
  input  logic [N-1:0] i_lo,
  input  logic [N-1:0] i_hi,
  input  logic         i_dir,
  output logic [N-1:0] o_next,
  output logic         o_at_limit
);

  // One extra bit so neither the sum nor the floor compare can wrap.
  logic [N:0] w_sum;
  logic [N:0] w_floor;

  assign w_sum   = {1'b0, i_cur} + {1'b0, i_step};
  assign w_floor = {1'b0, i_lo} + {1'b0, i_step};

  always_comb begin
    o_next     = i_cur;
    o_at_limit = 1'b0;
    if (i_dir) begin
      o_next     = (w_sum > {1'b0, i_hi}) ? i_hi : w_sum[N-1:0];
      o_at_limit = (i_cur >= i_hi);
    end else begin
      o_next     = ({1'b0, i_cur} < w_floor) ? i_lo : (i_cur - i_step);
      o_at_limit = (i_cur <= i_lo);
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Stepped frequency-sweep sequencer feeding the DDS frequency word.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, abort        : begin a sweep (IDLE only) / stop a running sweep
//   mode                : 00 up, 01 down, 10 triangle, 11 sawtooth
//   fw_lo, fw_hi        : sweep bounds; fw_step increment; dwell cycles per word (0 = 1)
//   freq_word           : current word to the DDS
//   busy, done          : sweeping / single sweep finished pulse
//   step_stb, err       : first cycle of a new word / rejected start pulse
module dds_sweep_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [N-1:0]  fw_lo,
  input  logic [N-1:0]  fw_hi,
  input  logic [N-1:0]  fw_step,
  input  logic [DW-1:0] dwell,
  output logic [N-1:0]  freq_word,
  output logic          busy,
  output logic          done,
  output logic          step_stb,
  output logic          err
);

  state_e        r_state, w_state_nxt;
  mode_e         r_mode, w_mode_nxt;
  logic [N-1:0]  r_lo, w_lo_nxt, r_hi, w_hi_nxt, r_step, w_step_nxt;
  logic [N-1:0]  r_freq, w_freq_nxt;
  logic [DW-1:0] r_dwell, w_dwell_nxt, r_cnt, w_cnt_nxt, w_dwell_eff;
  logic          r_dir, w_dir_nxt, r_stb, w_stb_nxt, r_err, w_err_nxt;

  logic [N-1:0]  w_fwd_next, w_rev_next, w_take_word;
  logic          w_fwd_lim, w_rev_lim, w_take, w_flip;

  assign w_dwell_eff = (dwell == '0) ? DW'(1) : dwell;

  // Forward step follows the current direction; the reverse instance supplies the
  // first word after a triangle turnaround. Both limits set means lo == hi.
  dds_step_alu #(.N(N)) u_alu_fwd (
    .i_cur      (r_freq),
    .i_step     (r_step),
    .i_lo       (r_lo),
    .i_hi       (r_hi),
    .i_dir      (r_dir),
    .o_next     (w_fwd_next),
    .o_at_limit (w_fwd_lim)
  );

  dds_step_alu #(.N(N)) u_alu_rev (
    .i_cur      (r_freq),
    .i_step     (r_step),
    .i_lo       (r_lo),
    .i_hi       (r_hi),
    .i_dir      (~r_dir),
    .o_next     (w_rev_next),
    .o_at_limit (w_rev_lim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= MODE_UP;
      r_lo    <= '0;
      r_hi    <= '0;
      r_step  <= '0;
      r_freq  <= '0;
      r_dwell <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b1;
      r_stb   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_lo    <= w_lo_nxt;
      r_hi    <= w_hi_nxt;
      r_step  <= w_step_nxt;
      r_freq  <= w_freq_nxt;
      r_dwell <= w_dwell_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_stb   <= w_stb_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_lo_nxt    = r_lo;
    w_hi_nxt    = r_hi;
    w_step_nxt  = r_step;
    w_freq_nxt  = r_freq;
    w_dwell_nxt = r_dwell;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_stb_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_take      = 1'b0;
    w_take_word = w_fwd_next;
    w_flip      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          if ((fw_step == '0) || (fw_lo > fw_hi)) begin
            w_err_nxt = 1'b1;
          end else begin
            w_mode_nxt  = mode_e'(mode);
            w_lo_nxt    = fw_lo;
            w_hi_nxt    = fw_hi;
            w_step_nxt  = fw_step;
            w_dwell_nxt = w_dwell_eff;
            w_cnt_nxt   = w_dwell_eff - DW'(1);
            w_dir_nxt   = (mode != MODE_DN);
            w_freq_nxt  = (mode == MODE_DN) ? fw_hi : fw_lo;
            w_stb_nxt   = 1'b1;
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - DW'(1);
        end else begin
          unique case (r_mode)
            MODE_UP, MODE_DN: begin
              if (w_fwd_lim) w_state_nxt = S_FINISH;
              else           w_take      = 1'b1;
            end
            MODE_TRI: begin
              // lo == hi: hold the single word without further strobes.
              if (!(w_fwd_lim && w_rev_lim)) begin
                w_take = 1'b1;
                if (w_fwd_lim) begin
                  w_flip      = 1'b1;
                  w_take_word = w_rev_next;
                end
              end
            end
            MODE_SAW: begin
              if (!(w_fwd_lim && w_rev_lim)) begin
                w_take = 1'b1;
                if (w_fwd_lim) w_take_word = r_lo;
              end
            end
            default: ;
          endcase
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase

    if (w_take) begin
      w_freq_nxt = w_take_word;
      w_stb_nxt  = 1'b1;
      w_cnt_nxt  = r_dwell - DW'(1);
    end
    if (w_flip) w_dir_nxt = ~r_dir;
  end

  assign freq_word = r_freq;
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_FINISH);
  assign step_stb  = r_stb;
  assign err       = r_err;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: a sequence-level model builds the whole
// expected per-cycle output stream for each accepted sweep and is compared every cycle;
// directed tests additionally pin recorded output sequences against literal values.
module tb_dds_sweep_ctrl;

  localparam int CAP = 300;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [23:0] fw_lo = '0, fw_hi = '0, fw_step = '0;
  logic [15:0] dwell = '0;
  logic [23:0] freq_word;
  logic        busy, done, step_stb, err;

  dds_sweep_ctrl #(.N(24), .DW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .fw_lo     (fw_lo),
    .fw_hi     (fw_hi),
    .fw_step   (fw_step),
    .dwell     (dwell),
    .freq_word (freq_word),
    .busy      (busy),
    .done      (done),
    .step_stb  (step_stb),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] f;
    logic        busy;
    logic        done;
    logic        stb;
    logic        err;
  } rec_t;

  int n_total = 0;
  int n_pass  = 0;

  rec_t exp_q[$];
  logic [23:0] log_f[$];
  logic        log_busy[$], log_done[$], log_stb[$], log_err[$];

  logic [23:0] exp_up [15];
  logic [23:0] exp_tri [18];
  logic [23:0] exp_saw [5];
  logic [23:0] exp_rst [5];

  function automatic rec_t mk(logic [23:0] f, logic b, logic d, logic s, logic e);
    rec_t r;
    r.f = f; r.busy = b; r.done = d; r.stb = s; r.err = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected stream of one sweep: word lists from plain arithmetic, each word
  // repeated for the dwell, strobe on its first cycle, finish record for single sweeps.
  task automatic build(input logic [1:0] m, input longint lo, input longint hi,
                       input longint st, input int dw);
    longint up[$], dn[$], words[$];
    longint w;
    int de;
    de = (dw == 0) ? 1 : dw;
    w = lo;
    forever begin
      up.push_back(w);
      if (w >= hi) break;
      w = w + st;
      if (w > hi) w = hi;
    end
    w = hi;
    forever begin
      dn.push_back(w);
      if (w <= lo) break;
      w = w - st;
      if (w < lo) w = lo;
    end
    exp_q.delete();
    if (m[1] && lo == hi) begin
      for (int k = 0; k < CAP; k++) exp_q.push_back(mk(24'(lo), 1, 0, k == 0, 0));
    end else begin
      case (m)
        2'b00: words = up;
        2'b01: words = dn;
        2'b10: begin
          words = up;
          while (words.size() < CAP) begin
            for (int i = 1; i < dn.size(); i++) words.push_back(dn[i]);
            for (int i = 1; i < up.size(); i++) words.push_back(up[i]);
          end
        end
        default: while (words.size() < CAP) foreach (up[i]) words.push_back(up[i]);
      endcase
      foreach (words[i])
        for (int k = 0; k < de; k++)
          if (exp_q.size() < CAP) exp_q.push_back(mk(24'(words[i]), 1, 0, k == 0, 0));
      if (!m[1]) exp_q.push_back(mk(24'(words[words.size()-1]), 0, 1, 0, 0));
    end
  endtask

  // Model advance at each rising edge, then compare just after it.
  initial begin
    rec_t shown, nxt;
    shown = mk(0, 0, 0, 0, 0);
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_q.delete();
        nxt = mk(0, 0, 0, 0, 0);
      end else if (shown.busy && abort) begin
        exp_q.delete();
        nxt = mk(shown.f, 0, 0, 0, 0);
      end else if (exp_q.size() > 0) begin
        nxt = exp_q.pop_front();
      end else if (!shown.busy && !shown.done && start && !abort) begin
        if (fw_step == 0 || fw_lo > fw_hi) begin
          nxt = mk(shown.f, 0, 0, 0, 1);
        end else begin
          build(mode, longint'(fw_lo), longint'(fw_hi), longint'(fw_step), int'(dwell));
          nxt = exp_q.pop_front();
        end
      end else begin
        nxt = mk(shown.f, 0, 0, 0, 0);
      end
      shown = nxt;
      #1;
      chk("freq_word", freq_word, shown.f);
      chk("busy", busy, shown.busy);
      chk("done", done, shown.done);
      chk("step_stb", step_stb, shown.stb);
      chk("err", err, shown.err);
      log_f.push_back(freq_word);
      log_busy.push_back(busy);
      log_done.push_back(done);
      log_stb.push_back(step_stb);
      log_err.push_back(err);
    end
  end

  task automatic clear_log();
    log_f.delete(); log_busy.delete(); log_done.delete(); log_stb.delete(); log_err.delete();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Inputs are scrambled after the start edge: latched config must not follow them.
  task automatic do_start(input logic [1:0] m, input logic [23:0] lo, input logic [23:0] hi,
                          input logic [23:0] st, input logic [15:0] dw);
    @(negedge clk);
    mode = m; fw_lo = lo; fw_hi = hi; fw_step = st; dwell = dw; start = 1'b1;
    clear_log();
    @(negedge clk);
    start   = 1'b0;
    mode    = 2'($urandom);
    fw_lo   = 24'($urandom);
    fw_hi   = 24'($urandom);
    fw_step = 24'($urandom);
    dwell   = 16'($urandom);
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic check_up_log(input string name);
    int n_stb;
    n_stb = 0;
    for (int i = 0; i < 15; i++) begin
      chk({name, "_freq"}, log_f[i], exp_up[i]);
      if (log_stb[i]) n_stb++;
    end
    chk({name, "_stb_count"}, 24'(n_stb), 24'd4);
    chk({name, "_stb_idx9"}, log_stb[9], 1'b1);
    chk({name, "_busy_last_dwell"}, log_busy[11], 1'b1);
    chk({name, "_done_idx12"}, log_done[12], 1'b1);
    chk({name, "_busy_idx12"}, log_busy[12], 1'b0);
    chk({name, "_done_idx13"}, log_done[13], 1'b0);
  endtask

  initial begin
    int n;
    exp_up  = '{24'd0, 24'd0, 24'd0, 24'd40, 24'd40, 24'd40, 24'd80, 24'd80, 24'd80,
                24'd100, 24'd100, 24'd100, 24'd100, 24'd100, 24'd100};
    exp_tri = '{24'd50, 24'd50, 24'd100, 24'd100, 24'd150, 24'd150, 24'd200, 24'd200,
                24'd150, 24'd150, 24'd100, 24'd100, 24'd50, 24'd50, 24'd100, 24'd100,
                24'd150, 24'd150};
    exp_saw = '{24'h000000, 24'h800000, 24'hFFFFFF, 24'h000000, 24'h800000};
    exp_rst = '{24'd7, 24'd8, 24'd9, 24'd9, 24'd9};

    // Reset values.
    wait_cyc(3);
    chk("rst_freq", freq_word, 24'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_outs", {done, step_stb, err}, 3'b000);
    rst_n = 1'b1;
    wait_cyc(2);

    // Single up sweep.
    do_start(2'b00, 24'd0, 24'd100, 24'd40, 16'd3);
    wait_cyc(14);
    check_up_log("up");

    // Triangle, aborted on the last dwell cycle of 150 (abort beats the step).
    do_start(2'b10, 24'd50, 24'd200, 24'd50, 16'd2);
    wait_cyc(17);
    pulse_abort();
    wait_cyc(2);
    n = 0;
    for (int i = 0; i < 18; i++) chk("tri_freq", log_f[i], exp_tri[i]);
    foreach (log_done[i]) if (log_done[i]) n++;
    chk("tri_no_done", 24'(n), 24'd0);
    chk("tri_abort_freq", log_f[18], 24'd150);
    chk("tri_abort_busy", log_busy[18], 1'b0);

    // Sawtooth, full-range with clamp, dwell 0 acts as 1.
    do_start(2'b11, 24'h000000, 24'hFFFFFF, 24'h800000, 16'd0);
    wait_cyc(4);
    pulse_abort();
    wait_cyc(1);
    for (int i = 0; i < 5; i++) begin
      chk("saw_freq", log_f[i], exp_saw[i]);
      chk("saw_stb", log_stb[i], 1'b1);
    end
    chk("saw_abort_freq", log_f[5], 24'h800000);
    chk("saw_abort_busy", log_busy[5], 1'b0);

    // Rejected starts.
    do_start(2'b00, 24'd0, 24'd100, 24'd0, 16'd3);
    wait_cyc(1);
    chk("rej_step0_err", log_err[0], 1'b1);
    chk("rej_step0_busy", log_busy[0], 1'b0);
    chk("rej_step0_freq", log_f[0], 24'h800000);
    chk("rej_step0_err_once", log_err[1], 1'b0);
    do_start(2'b00, 24'd10, 24'd5, 24'd1, 16'd1);
    wait_cyc(1);
    chk("rej_lohi_err", log_err[0], 1'b1);
    chk("rej_lohi_busy", log_busy[0], 1'b0);

    // Start while busy is ignored.
    do_start(2'b00, 24'd0, 24'd100, 24'd40, 16'd3);
    wait_cyc(2);
    mode = 2'b01; fw_lo = 24'd0; fw_hi = 24'd500; fw_step = 24'd1; dwell = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(11);
    check_up_log("busy_start");
    n = 0;
    foreach (log_err[i]) if (log_err[i]) n++;
    chk("busy_start_no_err", 24'(n), 24'd0);

    // Single down with lo == hi.
    do_start(2'b01, 24'd200, 24'd200, 24'd5, 16'd4);
    wait_cyc(6);
    n = 0;
    for (int i = 0; i < 7; i++) begin
      chk("eq_freq", log_f[i], 24'd200);
      if (log_stb[i]) n++;
    end
    chk("eq_stb_count", 24'(n), 24'd1);
    chk("eq_busy_idx3", log_busy[3], 1'b1);
    chk("eq_done_idx4", log_done[4], 1'b1);

    // Start and abort together in IDLE: nothing happens.
    @(negedge clk);
    mode = 2'b00; fw_lo = 24'd0; fw_hi = 24'd100; fw_step = 24'd40; dwell = 16'd3;
    start = 1'b1; abort = 1'b1;
    clear_log();
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    wait_cyc(2);
    chk("sa_busy", log_busy[0], 1'b0);
    chk("sa_stb", log_stb[0], 1'b0);
    chk("sa_err", log_err[0], 1'b0);
    chk("sa_freq", log_f[1], 24'd200);

    // Asynchronous reset mid-sweep, then a fresh sweep.
    do_start(2'b00, 24'd1000, 24'd5000, 24'd100, 16'd5);
    wait_cyc(7);
    chk("pre_rst_freq", freq_word, 24'd1100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_freq", freq_word, 24'd0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_stb", step_stb, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start(2'b00, 24'd7, 24'd9, 24'd1, 16'd1);
    wait_cyc(4);
    for (int i = 0; i < 5; i++) chk("post_rst_freq", log_f[i], exp_rst[i]);
    chk("post_rst_done", log_done[3], 1'b1);
    chk("post_rst_busy", log_busy[2], 1'b1);

    wait_cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
